// File: rtl/hazard_scoreboard.sv
// Tracks destination writes in flight past decode. It stalls D on use-before-ready,
// selects forwarding sources, and counts the cycles the mult/div unit is busy.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [TW-1:0] tnew_d,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [AW-1:0] dst_d,
  input  logic          uses_md_d,
  input  logic          md_start,
  input  logic          md_is_div,
  input  logic          flush,
  output logic          stall,
  output logic [FW-1:0] fwd_rs_sel,
  output logic [FW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef struct packed {
    logic          stall;
    logic [FW-1:0] sel;
  } lookup_t;

  logic [DEPTH-1:0]         ent_valid_q, ent_valid_d;
  logic [DEPTH-1:0][AW-1:0] ent_addr_q, ent_addr_d;
  logic [DEPTH-1:0][TW-1:0] ent_tnew_q, ent_tnew_d;
  logic [CW-1:0]            md_cnt_q, md_cnt_d;

  lookup_t rs_res, rt_res;
  logic    stall_md;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  function automatic lookup_t lookup(
    input logic [AW-1:0]              op,
    input logic [TW-1:0]              tuse,
    input logic [DEPTH-1:0]           v,
    input logic [DEPTH-1:0][AW-1:0]   a,
    input logic [DEPTH-1:0][TW-1:0]   t
  );
    lookup_t       res;
    logic          hit;
    logic          used;
    logic [TW-1:0] t_hit;
    logic [FW-1:0] idx;
    hit   = 1'b0;
    t_hit = '0;
    idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k] && (a[k] == op) && (op != '0)) begin
        hit   = 1'b1;
        t_hit = t[k];
        idx   = FW'(k + 1);
      end
    end
    used      = (tuse != {TW{1'b1}});
    res.stall = used && hit && (t_hit > tuse);
    res.sel   = (used && hit && (t_hit == '0)) ? idx : '0;
    return res;
  endfunction

  assign rs_res = lookup(rs_d, tuse_rs_d, ent_valid_q, ent_addr_q, ent_tnew_q);
  assign rt_res = lookup(rt_d, tuse_rt_d, ent_valid_q, ent_addr_q, ent_tnew_q);

  assign md_busy    = (md_cnt_q != '0);
  assign stall_md   = uses_md_d & (md_busy | md_start);
  assign stall      = rs_res.stall | rt_res.stall | stall_md;
  assign fwd_rs_sel = rs_res.sel;
  assign fwd_rt_sel = rt_res.sel;

  // Flush leaves every entry at its zero default, beating both the shift and the new load.
  always_comb begin
    ent_valid_d = '0;
    ent_addr_d  = '0;
    ent_tnew_d  = '0;
    if (!flush) begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid_d[k] = ent_valid_q[k-1];
        ent_addr_d[k]  = ent_addr_q[k-1];
        ent_tnew_d[k]  = dec_sat(ent_tnew_q[k-1]);
      end
      if (!stall) begin
        ent_valid_d[0] = (dst_d != '0);
        ent_addr_d[0]  = dst_d;
        ent_tnew_d[0]  = dec_sat(tnew_d);
      end
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
      ent_addr_q  <= '0;
      ent_tnew_q  <= '0;
      md_cnt_q    <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_addr_q  <= ent_addr_d;
      ent_tnew_q  <= ent_tnew_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a directed vector table, short corner-case
// sequences, and a randomized run against an issue-history reference model.
module tb_hazard_scoreboard;

  localparam int DEPTH     = 3;
  localparam int AW        = 5;
  localparam int TW        = 2;
  localparam int MULT_LAT  = 5;
  localparam int DIV_LAT   = 10;
  localparam int FW        = 2;
  localparam int TUSE_NONE = (1 << TW) - 1;
  localparam int HIST      = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic [AW-1:0] rs_d, rt_d, dst_d;
  logic          uses_md_d, md_start, md_is_div, flush;
  logic          stall;
  logic [FW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic          md_busy;

  typedef struct {
    logic [TW-1:0] tuseRs, tuseRt, tnew;
    logic [AW-1:0] rs, rt, dst;
    logic          usesMd, mdStart, mdIsDiv, flush;
    logic          expStall;
    logic [FW-1:0] expRs, expRt;
    logic          expBusy;
  } vec_t;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: what D issued each cycle, plus flush and mult/div history.
  bit histAcc[HIST];
  int histDst[HIST];
  int histTnew[HIST];
  int lastFlush;
  int mdStartCyc;
  int mdLat;

  hazard_scoreboard #(
    .DEPTH(DEPTH), .AW(AW), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .tnew_d(tnew_d),
    .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d),
    .uses_md_d(uses_md_d), .md_start(md_start), .md_is_div(md_is_div), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int tuseRs, input int tuseRt, input int tnew,
                              input int rs, input int rt, input int dst,
                              input int usesMd, input int mdStart, input int mdIsDiv,
                              input int fl, input int eStall, input int eRs,
                              input int eRt, input int eBusy);
    vec_t v;
    v.tuseRs = TW'(tuseRs);  v.tuseRt = TW'(tuseRt);  v.tnew = TW'(tnew);
    v.rs = AW'(rs);  v.rt = AW'(rt);  v.dst = AW'(dst);
    v.usesMd = 1'(usesMd);  v.mdStart = 1'(mdStart);  v.mdIsDiv = 1'(mdIsDiv);
    v.flush = 1'(fl);
    v.expStall = 1'(eStall);  v.expRs = FW'(eRs);  v.expRt = FW'(eRt);
    v.expBusy = 1'(eBusy);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    tuse_rs_d = v.tuseRs;  tuse_rt_d = v.tuseRt;  tnew_d = v.tnew;
    rs_d = v.rs;  rt_d = v.rt;  dst_d = v.dst;
    uses_md_d = v.usesMd;  md_start = v.mdStart;  md_is_div = v.mdIsDiv;
    flush = v.flush;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkValue({name, ".stall"}, int'(stall), int'(v.expStall));
    checkValue({name, ".fwd_rs"}, int'(fwd_rs_sel), int'(v.expRs));
    checkValue({name, ".fwd_rt"}, int'(fwd_rt_sel), int'(v.expRt));
    checkValue({name, ".md_busy"}, int'(md_busy), int'(v.expBusy));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(mk(3,3,0, 0,0,0, 0,0,0,0, 0,0,0,0));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", mk(3,3,0, 0,0,0, 0,0,0,0, 0,0,0,0));
    reset = 1'b0;
    nextCycle();
  endtask

  // Mult/div with a HI/LO reader held in D: count stall and busy cycles.
  task automatic seqMd(input bit isDiv);
    int stallCnt;
    int busyCnt;
    int lat;
    string tag;
    lat = isDiv ? DIV_LAT : MULT_LAT;
    tag = isDiv ? "div" : "mult";
    stallCnt = 0;
    busyCnt  = 0;
    resetDut();
    applyStimulus(mk(3,3,0, 0,0,0, 1,1,int'(isDiv),0, 0,0,0,0));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (md_busy) busyCnt++;
      if (!stall) break;
      nextCycle();
      md_start = 1'b0;
    end
    checkValue({tag, "_stall_cycles"}, stallCnt, lat + 1);
    checkValue({tag, "_busy_cycles"}, busyCnt, lat);
  endtask

  task automatic seqFlush();
    resetDut();
    applyStimulus(mk(3,3,3, 0,0,1, 0,0,0,0, 0,0,0,0));
    nextCycle();
    applyStimulus(mk(3,3,3, 0,0,2, 0,0,0,0, 0,0,0,0));
    nextCycle();
    applyStimulus(mk(3,3,3, 0,0,3, 0,1,0,0, 0,0,0,0));
    nextCycle();
    applyStimulus(mk(0,0,0, 2,3,0, 0,0,0,1, 1,0,0,1));
    @(negedge clk);
    checkOutput("flush_cycle", mk(0,0,0, 2,3,0, 0,0,0,1, 1,0,0,1));
    nextCycle();
    applyStimulus(mk(0,0,0, 2,3,0, 0,0,0,0, 0,0,0,1));
    @(negedge clk);
    checkOutput("after_flush", mk(0,0,0, 2,3,0, 0,0,0,0, 0,0,0,1));
    nextCycle();
    applyStimulus(mk(3,3,3, 0,0,6, 0,0,0,1, 0,0,0,1));
    nextCycle();
    applyStimulus(mk(0,3,0, 6,0,0, 0,0,0,0, 0,0,0,1));
    @(negedge clk);
    checkOutput("flush_kills_load", mk(0,3,0, 6,0,0, 0,0,0,0, 0,0,0,1));
    nextCycle();
  endtask

  task automatic seqAsyncReset();
    vec_t idleRead;
    idleRead = mk(0,3,0, 7,0,0, 1,0,0,0, 0,0,0,0);
    applyStimulus(mk(3,3,3, 0,0,7, 0,1,1,0, 0,0,0,0));
    nextCycle();
    applyStimulus(idleRead);
    #1;
    checkValue("pre_reset_stall", int'(stall), 1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", idleRead);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_released", idleRead);
    nextCycle();
    @(negedge clk);
    checkOutput("first_edge_after_reset", idleRead);
    nextCycle();
  endtask

  // Look back over instructions issued in the last DEPTH cycles; nearest issue wins.
  function automatic void modelOperand(input int op, input int tuse, input int now,
                                       output bit st, output int sel);
    int c;
    int rem;
    st  = 1'b0;
    sel = 0;
    if (tuse == TUSE_NONE || op == 0) return;
    for (int j = 1; j <= DEPTH; j++) begin
      c = now - j;
      if (c < 0 || c <= lastFlush) return;
      if (histAcc[c] && histDst[c] == op) begin
        rem = histTnew[c] - j;
        if (rem < 0) rem = 0;
        st  = (rem > tuse);
        sel = (rem == 0) ? j : 0;
        return;
      end
    end
  endfunction

  task automatic randomPhase(input int cycles);
    vec_t r;
    bit   stRs, stRt, busy;
    int   selRs, selRt;
    resetDut();
    lastFlush  = -1;
    mdStartCyc = -1000;
    mdLat      = 0;
    for (int now = 0; now < cycles; now++) begin
      r = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             int'($urandom_range(0,5) == 0), int'($urandom_range(0,9) == 0),
             $urandom_range(0,1), int'($urandom_range(0,19) == 0), 0,0,0,0);
      modelOperand(int'(r.rs), int'(r.tuseRs), now, stRs, selRs);
      modelOperand(int'(r.rt), int'(r.tuseRt), now, stRt, selRt);
      busy = (now > mdStartCyc) && (now - mdStartCyc <= mdLat);
      r.expBusy  = busy;
      r.expStall = stRs | stRt | (r.usesMd & (busy | r.mdStart));
      r.expRs    = FW'(selRs);
      r.expRt    = FW'(selRt);
      applyStimulus(r);
      @(negedge clk);
      checkOutput($sformatf("rand[%0d]", now), r);
      histAcc[now]  = !r.expStall && (r.dst != '0);
      histDst[now]  = int'(r.dst);
      histTnew[now] = int'(r.tnew);
      if (r.flush) lastFlush = now;
      if (r.mdStart) begin
        mdStartCyc = now;
        mdLat      = r.mdIsDiv ? DIV_LAT : MULT_LAT;
      end
      nextCycle();
    end
  endtask

  initial begin
    vec_t vecs[14];
    reset = 1'b1;
    vecs[0]  = mk(3,3,0, 0,0,0,   0,0,0,0, 0,0,0,0);
    vecs[1]  = mk(3,3,3, 0,0,8,   0,0,0,0, 0,0,0,0);
    vecs[2]  = mk(1,3,2, 8,0,10,  0,0,0,0, 1,0,0,0);
    vecs[3]  = mk(1,3,2, 8,0,10,  0,0,0,0, 0,0,0,0);
    vecs[4]  = mk(0,1,0, 8,10,0,  0,0,0,0, 0,3,0,0);
    vecs[5]  = mk(0,0,1, 10,10,10, 0,0,0,0, 0,2,2,0);
    vecs[6]  = mk(0,3,2, 10,0,4,  0,0,0,0, 0,1,0,0);
    vecs[7]  = mk(0,3,0, 4,10,0,  0,0,0,0, 1,0,0,0);
    vecs[8]  = mk(0,2,0, 4,10,0,  0,1,0,0, 0,2,3,0);
    vecs[9]  = mk(3,3,0, 0,0,0,   1,0,0,1, 1,0,0,1);
    vecs[10] = mk(0,3,0, 4,0,0,   0,0,0,0, 0,0,0,1);
    vecs[11] = mk(0,0,0, 0,0,0,   0,0,0,0, 0,0,0,1);
    vecs[12] = mk(3,3,0, 0,0,0,   0,1,1,0, 0,0,0,1);
    vecs[13] = mk(3,3,0, 0,0,0,   1,0,0,0, 1,0,0,1);

    resetDut();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec[%0d]", i), vecs[i]);
      nextCycle();
    end

    seqFlush();
    seqAsyncReset();
    seqMd(1'b1);
    seqMd(1'b0);
    randomPhase(3000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
